jkff_checker: RTL and testbench

- Synthesizable response checker for the JK flip-flop interface. It is the receiving/checking end of the j/k stimulus stream the flip-flop bench drives.
- Samples the same j, k, q and q_bar the flip-flop sees on every rising clk edge.
- Keeps a one-bit reference model and flags any cycle where q or q_bar disagrees with JK semantics.
- Counts checks and errors, and captures the first failure for debug or self-test readout.

---
 rtl/jkff_checker.sv | 101 ++++++++++
 tb/tb_jkff_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/jkff_checker.sv
// Response checker for a JK flip-flop: tracks a one-bit reference model with one
// cycle of latency, counts compares and mismatches, and captures the first failure.
module jkff_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  input  logic             q_bar,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_jk,
  output logic             first_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       exp_q;
  logic [1:0] prev_jk;
  logic       compare;
  logic       mismatch;
  logic       load_model;

  function automatic logic jk_next(input logic qv, input logic jv, input logic kv);
    case ({jv, kv})
      2'b00:   jk_next = qv;
      2'b01:   jk_next = 1'b0;
      2'b10:   jk_next = 1'b1;
      default: jk_next = ~qv;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = SYNC;
      SYNC:    state_d = en ? CHECK : IDLE;
      CHECK:   state_d = en ? CHECK : IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = en ? SYNC : IDLE;
  end

  // clr wins over a mismatch on the same edge, so it masks the compare entirely.
  assign compare    = (state_q == CHECK) && en && !clr;
  assign mismatch   = compare && ((q != exp_q) || (q_bar != ~q));
  assign load_model = en && !clr && ((state_q == SYNC) || (state_q == CHECK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      exp_q      <= 1'b0;
      prev_jk    <= 2'b00;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      chk_count  <= '0;
      err_count  <= '0;
      first_jk   <= 2'b00;
      first_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_jk <= {j, k};
      if (clr) begin
        err_pulse  <= 1'b0;
        err_sticky <= 1'b0;
        chk_count  <= '0;
        err_count  <= '0;
        first_jk   <= 2'b00;
        first_q    <= 1'b0;
      end else begin
        err_pulse <= mismatch;
        // Model follows the observed q so a single fault yields a single error.
        if (load_model) exp_q <= jk_next(q, j, k);
        if (compare && !(&chk_count)) chk_count <= chk_count + CNT_W'(1);
        if (mismatch) begin
          if (!(&err_count)) err_count <= err_count + CNT_W'(1);
          err_sticky <= 1'b1;
          if (!err_sticky) begin
            first_jk <= prev_jk;
            first_q  <= q;
          end
        end
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_jkff_checker.sv
// Directed bench for jkff_checker: a behavioural JK flip-flop drives q/q_bar,
// with overrides for stuck-at and q_bar glitch faults.
module tb_jkff_checker;

  logic clk = 1'b0;
  logic rst_n, en, clr, j, k;
  logic ff_q = 1'b0;
  logic force_en, force_val, qb_glitch;
  logic q, q_bar;

  logic [1:0]  state, state4;
  logic        err_pulse, err_sticky, err_pulse4, err_sticky4;
  logic [15:0] chk_count, err_count;
  logic [3:0]  chk_count4, err_count4;
  logic [1:0]  first_jk, first_jk4;
  logic        first_q, first_q4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference flip-flop under observation
  always @(posedge clk) begin
    case ({j, k})
      2'b00: ff_q <= ff_q;
      2'b01: ff_q <= 1'b0;
      2'b10: ff_q <= 1'b1;
      default: ff_q <= ~ff_q;
    endcase
  end

  assign q     = force_en ? force_val : ff_q;
  assign q_bar = qb_glitch ? q : ~q;

  jkff_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .j(j), .k(k), .q(q), .q_bar(q_bar),
    .state(state), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .chk_count(chk_count), .err_count(err_count), .first_jk(first_jk), .first_q(first_q)
  );

  jkff_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .j(j), .k(k), .q(q), .q_bar(q_bar),
    .state(state4), .err_pulse(err_pulse4), .err_sticky(err_sticky4),
    .chk_count(chk_count4), .err_count(err_count4), .first_jk(first_jk4), .first_q(first_q4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; j = 1'b0; k = 1'b0;
    force_en = 1'b0; force_val = 1'b0; qb_glitch = 1'b0;
    step();
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", err_pulse); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", err_sticky); end
    checks++; if (chk_count !== 16'd0) begin errors++; $display("FAIL reset_chk got %0d exp 0", chk_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
    checks++; if (first_jk !== 2'b00) begin errors++; $display("FAIL reset_first_jk got %b exp 00", first_jk); end
    checks++; if (first_q !== 1'b0) begin errors++; $display("FAIL reset_first_q got %b exp 0", first_q); end
  endtask

  task automatic test_basic();
    rst_n = 1'b1;
    step();
    en = 1'b1;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_sync got %0d exp 1", state); end
    for (int i = 0; i < 32; i++) begin
      {j, k} = 2'(i % 4);
      step();
      if (i == 0) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_check_state got %0d exp 2", state); end
      end
    end
    checks++; if (chk_count !== 16'd31) begin errors++; $display("FAIL basic_chk got %0d exp 31", chk_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL basic_err got %0d exp 0", err_count); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL basic_sticky got %b exp 0", err_sticky); end
  endtask

  task automatic test_stuck();
    j = 1'b1; k = 1'b0; clr = 1'b1;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL stuck_clr_state got %0d exp 1", state); end
    clr = 1'b0; force_en = 1'b1; force_val = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL stuck_pulse%0d got %b exp 1", i, err_pulse); end
    end
    checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL stuck_err got %0d exp 4", err_count); end
    checks++; if (chk_count !== 16'd4) begin errors++; $display("FAIL stuck_chk got %0d exp 4", chk_count); end
    checks++; if (first_jk !== 2'b10) begin errors++; $display("FAIL stuck_first_jk got %b exp 10", first_jk); end
    checks++; if (first_q !== 1'b0) begin errors++; $display("FAIL stuck_first_q got %b exp 0", first_q); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL stuck_sticky got %b exp 1", err_sticky); end
    force_en = 1'b0;
  endtask

  task automatic test_glitch();
    j = 1'b0; k = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL glitch_pre got %b exp 0", err_pulse); end
    qb_glitch = 1'b1;
    step();
    qb_glitch = 1'b0;
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL glitch_pulse got %b exp 1", err_pulse); end
    checks++; if (first_jk !== 2'b00) begin errors++; $display("FAIL glitch_first_jk got %b exp 00", first_jk); end
    step();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL glitch_after got %b exp 0", err_pulse); end
    step();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL glitch_after2 got %b exp 0", err_pulse); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL glitch_err got %0d exp 1", err_count); end
    checks++; if (chk_count !== 16'd4) begin errors++; $display("FAIL glitch_chk got %0d exp 4", chk_count); end
  endtask

  task automatic test_saturate();
    j = 1'b1; k = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; force_en = 1'b1; force_val = 1'b0;
    step();
    for (int i = 0; i < 20; i++) step();
    checks++; if (err_count4 !== 4'd15) begin errors++; $display("FAIL sat_err4 got %0d exp 15", err_count4); end
    checks++; if (chk_count4 !== 4'd15) begin errors++; $display("FAIL sat_chk4 got %0d exp 15", chk_count4); end
    checks++; if (err_pulse4 !== 1'b1) begin errors++; $display("FAIL sat_pulse4 got %b exp 1", err_pulse4); end
    checks++; if (err_count !== 16'd20) begin errors++; $display("FAIL sat_err16 got %0d exp 20", err_count); end
    checks++; if (chk_count !== 16'd20) begin errors++; $display("FAIL sat_chk16 got %0d exp 20", chk_count); end
    force_en = 1'b0;
  endtask

  task automatic test_clr_priority();
    j = 1'b0; k = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL clrpri_pre_state got %0d exp 2", state); end
    qb_glitch = 1'b1; clr = 1'b1;
    step();
    qb_glitch = 1'b0; clr = 1'b0;
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clrpri_err got %0d exp 0", err_count); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clrpri_sticky got %b exp 0", err_sticky); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL clrpri_pulse got %b exp 0", err_pulse); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL clrpri_state got %0d exp 1", state); end
  endtask

  task automatic test_en_gap();
    j = 1'b1; k = 1'b1;
    step();
    step(); step(); step();
    checks++; if (chk_count !== 16'd3) begin errors++; $display("FAIL gap_pre_chk got %0d exp 3", chk_count); end
    en = 1'b0;
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL gap_idle got %0d exp 0", state); end
    step(); step();
    checks++; if (chk_count !== 16'd3) begin errors++; $display("FAIL gap_hold_chk got %0d exp 3", chk_count); end
    en = 1'b1;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL gap_sync got %0d exp 1", state); end
    step();
    checks++; if (chk_count !== 16'd3) begin errors++; $display("FAIL gap_sync_chk got %0d exp 3", chk_count); end
    step();
    checks++; if (chk_count !== 16'd4) begin errors++; $display("FAIL gap_resume_chk got %0d exp 4", chk_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL gap_err got %0d exp 0", err_count); end
  endtask

  task automatic test_async_reset();
    qb_glitch = 1'b1;
    step();
    qb_glitch = 1'b0;
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL ar_pre_pulse got %b exp 1", err_pulse); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ar_state got %0d exp 0", state); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL ar_pulse got %b exp 0", err_pulse); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL ar_sticky got %b exp 0", err_sticky); end
    checks++; if (chk_count !== 16'd0) begin errors++; $display("FAIL ar_chk got %0d exp 0", chk_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL ar_err got %0d exp 0", err_count); end
    #2 rst_n = 1'b1;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL ar_resync got %0d exp 1", state); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck();
    test_glitch();
    test_saturate();
    test_clr_priority();
    test_en_gap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
